// File: rtl/trace_record_sequencer.sv
// Per-instruction trace capture: in-order slot ring, IF/ID/EX/WB start/end
// time-stamping and in-order emission of completed records over valid/ready.
module trace_record_sequencer #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIME_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    if_start_i,
  input  logic [ADDR_WIDTH-1:0]   if_addr_i,
  input  logic                    if_end_i,
  input  logic [DATA_WIDTH-1:0]   if_instr_i,
  input  logic                    if_pass_through_i,
  input  logic                    id_start_i,
  input  logic                    id_end_i,
  input  logic                    ex_start_i,
  input  logic                    ex_end_i,
  input  logic                    wb_start_i,
  input  logic                    wb_end_i,
  output logic                    trace_valid_o,
  input  logic                    trace_ready_i,
  output logic [DATA_WIDTH-1:0]   trace_instr_o,
  output logic [ADDR_WIDTH-1:0]   trace_addr_o,
  output logic                    trace_pass_through_o,
  output logic [8*TIME_WIDTH-1:0] trace_time_o,
  output logic [TIME_WIDTH-1:0]   time_o,
  output logic                    stall_o,
  output logic                    overflow_o,
  output logic                    protocol_err_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [TIME_WIDTH-1:0]                   time_q;
  logic [PW-1:0]                           alloc_p, head_p;
  logic [3:0][PW-1:0]                      sp;     // per-stage oldest unfinished slot
  logic [3:0][CW-1:0]                      sq;     // per-stage waiting occupancy
  logic [CW-1:0]                           q_out, count;
  logic                                    overflow_q, perr_q;
  logic [DEPTH-1:0][ADDR_WIDTH-1:0]        addr_q;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]        instr_q;
  logic [DEPTH-1:0]                        pt_q;
  logic [DEPTH-1:0][7:0][TIME_WIDTH-1:0]   ts_q;

  logic [3:0] s_start, s_end, s_ok, s_adv, s_in;
  logic       pop, alloc, bad, up;

  assign s_start = {wb_start_i, ex_start_i, id_start_i, if_start_i};
  assign s_end   = {wb_end_i, ex_end_i, id_end_i, if_end_i};

  assign trace_valid_o        = (q_out != '0);
  assign stall_o              = (count == CW'(DEPTH));
  assign pop                  = trace_valid_o & trace_ready_i;
  assign alloc                = if_start_i & (~stall_o | pop);
  assign trace_addr_o         = addr_q[head_p];
  assign trace_instr_o        = instr_q[head_p];
  assign trace_pass_through_o = pt_q[head_p];
  assign trace_time_o         = ts_q[head_p];
  assign time_o               = time_q;
  assign overflow_o           = overflow_q;
  assign protocol_err_o       = perr_q;

  // Eligibility chains through the stages so a same-cycle upstream end makes
  // the instruction visible to the next stage's start/end in that cycle.
  always_comb begin
    s_in  = '0;
    s_ok  = '0;
    s_adv = '0;
    up    = alloc;
    for (int i = 0; i < 4; i++) begin
      s_in[i]  = up;
      s_ok[i]  = (sq[i] != '0) | up;
      s_adv[i] = s_end[i] & s_ok[i];
      up       = s_adv[i];
    end
    bad = |(((s_start & 4'b1110) | s_end) & ~s_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      time_q     <= '0;
      alloc_p    <= '0;
      head_p     <= '0;
      sp         <= '0;
      sq         <= '0;
      q_out      <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
      perr_q     <= 1'b0;
      addr_q     <= '0;
      instr_q    <= '0;
      pt_q       <= '0;
      ts_q       <= '0;
    end else begin
      time_q <= time_q + 1'b1;
      if (alloc) begin
        addr_q[alloc_p]  <= if_addr_i;
        ts_q[alloc_p][0] <= time_q;
        alloc_p          <= alloc_p + 1'b1;
      end
      if (s_adv[0]) begin
        instr_q[sp[0]] <= if_instr_i;
        pt_q[sp[0]]    <= if_pass_through_i;
      end
      for (int i = 0; i < 4; i++) begin
        if (i != 0 && s_start[i] && s_ok[i]) ts_q[sp[i]][3'(2*i)] <= time_q;
        if (s_adv[i]) ts_q[sp[i]][3'(2*i+1)] <= time_q;
        sp[i] <= sp[i] + PW'(s_adv[i]);
        sq[i] <= sq[i] + CW'(s_in[i]) - CW'(s_adv[i]);
      end
      q_out <= q_out + CW'(s_adv[3]) - CW'(pop);
      count <= count + CW'(alloc) - CW'(pop);
      if (pop) head_p <= head_p + 1'b1;
      if (if_start_i && !alloc) overflow_q <= 1'b1;
      if (bad) perr_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_trace_record_sequencer.sv
// Directed bench for trace_record_sequencer: table-driven overlap/backpressure
// vectors plus hand sequences for stamping, overflow, errors, wrap and reset.
module tb_trace_record_sequencer;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   st = '0;   // {wb_e, wb_s, ex_e, ex_s, id_e, id_s, if_e, if_s}
  logic         rdy = 1'b0;
  logic [31:0]  addr = '0, instr = '0;
  logic         pt = 1'b0;

  logic         valid, stall, ovf, perr, tpt;
  logic [31:0]  taddr, tinstr, now;
  logic [255:0] ttime;
  logic         w_valid, w_stall, w_ovf, w_perr, w_pt;
  logic [31:0]  w_addr, w_instr, w_time;
  logic [3:0]   w_now;

  int unsigned cyc = 0;
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  trace_record_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .if_start_i(st[0]), .if_addr_i(addr), .if_end_i(st[1]), .if_instr_i(instr),
    .if_pass_through_i(pt), .id_start_i(st[2]), .id_end_i(st[3]),
    .ex_start_i(st[4]), .ex_end_i(st[5]), .wb_start_i(st[6]), .wb_end_i(st[7]),
    .trace_valid_o(valid), .trace_ready_i(rdy), .trace_instr_o(tinstr),
    .trace_addr_o(taddr), .trace_pass_through_o(tpt), .trace_time_o(ttime),
    .time_o(now), .stall_o(stall), .overflow_o(ovf), .protocol_err_o(perr)
  );

  // Narrow counter instance so timestamp wrap is reachable in a few cycles.
  trace_record_sequencer #(.DEPTH(2), .TIME_WIDTH(4)) u_w (
    .clk(clk), .rst_n(rst_n),
    .if_start_i(st[0]), .if_addr_i(addr), .if_end_i(st[1]), .if_instr_i(instr),
    .if_pass_through_i(pt), .id_start_i(st[2]), .id_end_i(st[3]),
    .ex_start_i(st[4]), .ex_end_i(st[5]), .wb_start_i(st[6]), .wb_end_i(st[7]),
    .trace_valid_o(w_valid), .trace_ready_i(rdy), .trace_instr_o(w_instr),
    .trace_addr_o(w_addr), .trace_pass_through_o(w_pt), .trace_time_o(w_time),
    .time_o(w_now), .stall_o(w_stall), .overflow_o(w_ovf), .protocol_err_o(w_perr)
  );

  typedef struct {
    logic [7:0]  st;
    logic        rdy;
    logic [31:0] addr;
    logic [31:0] instr;
    logic        v;
    logic        s;
    int          k;   // record index expected at head, -1 = no record check
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic tick(input logic [7:0] s, input logic r, input logic [31:0] a,
                      input logic [31:0] ins, input logic p);
    st = s; rdy = r; addr = a; instr = ins; pt = p;
    step();
    st = '0; rdy = 1'b0; pt = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  function automatic logic [255:0] pk(input int unsigned a, b, c, d, e, f, g, h);
    return {h, g, f, e, d, c, b, a};
  endfunction

  function automatic logic [31:0] pk4(input int unsigned a, b, c, d, e, f, g, h);
    return {4'(h), 4'(g), 4'(f), 4'(e), 4'(d), 4'(c), 4'(b), 4'(a)};
  endfunction

  // Two cycles per stage, addr 0x100 / instr 0x13; returns start cycle.
  task automatic one_instr(output int unsigned base);
    base = cyc;
    tick(8'h01, 0, 32'h100, 0, 0);
    tick(8'h02, 0, 0, 32'h13, 0);
    for (int i = 2; i < 8; i++) tick(8'(1 << i), 0, 0, 0, 0);
  endtask

  initial begin
    int unsigned b;
    tbl[0]  = '{8'h01, 1'b0, 32'h200, 32'h0,    1'b0, 1'b0, -1};
    tbl[1]  = '{8'h03, 1'b0, 32'h204, 32'h1000, 1'b0, 1'b0, -1};
    tbl[2]  = '{8'h03, 1'b0, 32'h208, 32'h1001, 1'b0, 1'b0, -1};
    tbl[3]  = '{8'h03, 1'b0, 32'h20c, 32'h1002, 1'b0, 1'b0, -1};
    tbl[4]  = '{8'h02, 1'b0, 32'h0,   32'h1003, 1'b0, 1'b1, -1};
    tbl[5]  = '{8'hFC, 1'b0, 32'h0,   32'h0,    1'b0, 1'b1, -1};
    tbl[6]  = '{8'hFC, 1'b0, 32'h0,   32'h0,    1'b1, 1'b1, 0};
    tbl[7]  = '{8'hFC, 1'b0, 32'h0,   32'h0,    1'b1, 1'b1, 0};
    tbl[8]  = '{8'hFC, 1'b0, 32'h0,   32'h0,    1'b1, 1'b1, 0};
    tbl[9]  = '{8'h00, 1'b1, 32'h0,   32'h0,    1'b1, 1'b1, 0};
    tbl[10] = '{8'h00, 1'b1, 32'h0,   32'h0,    1'b1, 1'b0, 1};
    tbl[11] = '{8'h00, 1'b1, 32'h0,   32'h0,    1'b1, 1'b0, 2};
    tbl[12] = '{8'h00, 1'b1, 32'h0,   32'h0,    1'b1, 1'b0, 3};
    tbl[13] = '{8'h00, 1'b0, 32'h0,   32'h0,    1'b0, 1'b0, -1};

    // Reset and idle
    do_reset();
    repeat (5) step();
    chk("idle_time", now, 5);
    chk("idle_valid", valid, 0);
    chk("idle_stall", stall, 0);
    chk("idle_flags", {ovf, perr}, 0);
    chk("idle_rec", {taddr, tinstr, ttime}, 0);

    // Single instruction starting at t=10
    repeat (5) step();
    one_instr(b);
    chk("single_base", b, 10);
    chk("single_valid", valid, 1);
    chk("single_time", ttime, pk(10, 11, 12, 13, 14, 15, 16, 17));
    chk("single_addr", taddr, 32'h100);
    chk("single_instr", tinstr, 32'h13);
    chk("single_pt", tpt, 0);
    tick(8'h00, 1, 0, 0, 0);
    chk("single_popped", valid, 0);

    // Overlapped instructions with backpressure, table driven
    do_reset();
    b = cyc;
    for (int i = 0; i < 14; i++) begin
      st = tbl[i].st; rdy = tbl[i].rdy; addr = tbl[i].addr; instr = tbl[i].instr;
      chk($sformatf("tbl%0d_valid", i), valid, tbl[i].v);
      chk($sformatf("tbl%0d_stall", i), stall, tbl[i].s);
      if (tbl[i].k >= 0) begin
        chk($sformatf("tbl%0d_addr", i), taddr, 32'h200 + 4 * tbl[i].k);
        chk($sformatf("tbl%0d_instr", i), tinstr, 32'h1000 + tbl[i].k);
        chk($sformatf("tbl%0d_time", i), ttime,
            pk(b + tbl[i].k, b + tbl[i].k + 1, b + tbl[i].k + 5, b + tbl[i].k + 5,
               b + tbl[i].k + 5, b + tbl[i].k + 5, b + tbl[i].k + 5, b + tbl[i].k + 5));
      end
      step();
      st = '0; rdy = 1'b0;
    end
    chk("tbl_flags", {ovf, perr}, 0);

    // Push with simultaneous pop while full, then overflow, then error, then reset
    do_reset();
    tick(8'h01, 0, 32'h500, 0, 0);
    tick(8'h03, 0, 32'h504, 32'h2000, 0);
    tick(8'h01, 0, 32'h508, 0, 0);
    tick(8'h01, 0, 32'h50c, 0, 0);
    tick(8'hFC, 0, 0, 0, 0);
    chk("full_stall", stall, 1);
    chk("full_valid", valid, 1);
    chk("full_head", taddr, 32'h500);
    tick(8'h01, 1, 32'h510, 0, 0);
    chk("pushpop_ovf", ovf, 0);
    chk("pushpop_stall", stall, 1);
    chk("pushpop_valid", valid, 0);
    tick(8'h02, 0, 0, 32'h2001, 0);
    tick(8'hFC, 0, 0, 0, 0);
    chk("second_head", taddr, 32'h504);
    tick(8'h01, 0, 32'h600, 0, 0);
    chk("ovf_set", ovf, 1);
    tick(8'h00, 0, 0, 0, 0);
    chk("ovf_sticky", ovf, 1);
    tick(8'h08, 0, 0, 0, 0);
    chk("stray_id_err", perr, 1);
    chk("pre_rst_valid", valid, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", valid, 0);
    chk("rst_mid_stall", stall, 0);
    chk("rst_mid_flags", {ovf, perr}, 0);
    chk("rst_mid_out", {now, taddr, tinstr, tpt, ttime}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;

    // Protocol error with no fetched instruction, then single-cycle stages
    tick(8'h04, 0, 0, 0, 0);
    chk("perr_set", perr, 1);
    chk("perr_nochange", {valid, stall}, 0);
    b = cyc;
    tick(8'h01, 0, 32'h400, 0, 0);
    tick(8'h02, 0, 0, 32'h33, 1);
    tick(8'h0C, 0, 0, 0, 0);
    tick(8'h30, 0, 0, 0, 0);
    tick(8'hC0, 0, 0, 0, 0);
    chk("sc_valid", valid, 1);
    chk("sc_time", ttime, pk(b, b + 1, b + 2, b + 2, b + 3, b + 3, b + 4, b + 4));
    chk("sc_rec", {taddr, tinstr, tpt}, {32'h400, 32'h33, 1'b1});
    chk("sc_perr_sticky", perr, 1);

    // Timestamp wrap on the narrow-counter instance
    do_reset();
    repeat (14) step();
    chk("wrap_now", w_now, 4'hE);
    one_instr(b);
    chk("wrap_valid", w_valid, 1);
    chk("wrap_time", w_time, pk4(14, 15, 0, 1, 2, 3, 4, 5));
    chk("wrap_rec", {w_addr, w_instr, w_pt}, {32'h100, 32'h13, 1'b0});
    chk("wrap_flags", {w_stall, w_ovf, w_perr}, 0);
    chk("wide_time", ttime, pk(14, 15, 16, 17, 18, 19, 20, 21));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
